itcm: RTL and testbench



---
 rtl/itcm_pkg.sv | 10 +
 rtl/itcm_ram.sv | 22 ++
 rtl/itcm.sv | 101 ++++++++++
 tb/tb_itcm.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/itcm_pkg.sv
// Shared ISA sizes and constants used by the instruction TCM.
package itcm_pkg;
    localparam int RV_PC_SIZE = 32;
    localparam int RV_IR_SIZE = 32;

    // All-zero encoding is illegal in RV32I; returned for faulting fetches.
    localparam logic [RV_IR_SIZE-1:0] RV_IR_ILLEGAL = 32'h0000_0000;

    localparam logic [15:0] FAULT_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/itcm_ram.sv
// Single-port synchronous RAM, DEPTH x 32, one-cycle registered read.
// Written as a plain array so a technology macro can be dropped in.
module itcm_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) r_mem[i_addr] <= i_wdata;
            else      o_rdata       <= r_mem[i_addr];
        end
    end
endmodule

// File: rtl/itcm.sv
// Instruction TCM: in-order fetch responses with a 2-entry response buffer,
// bypass for the empty-buffer case, and a word-write load port.
module itcm
    import itcm_pkg::*;
#(
    parameter int              DEPTH     = 4096,
    parameter logic [31:0]     BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fch_req_vld,
    output logic                  fch_req_rdy,
    input  logic [RV_PC_SIZE-1:0] fch_req_pc,
    output logic                  fch_rsp_vld,
    input  logic                  fch_rsp_rdy,
    output logic [RV_IR_SIZE-1:0] fch_rsp_ir,
    input  logic                  ld_vld,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic [15:0]           fault_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [RV_PC_SIZE-1:0] w_off;
    logic                  w_fault;
    logic                  w_req_hsk;
    logic                  w_rsp_hsk;
    logic [2:0]            w_occ;
    logic [31:0]           w_ram_rdata;
    logic [RV_IR_SIZE-1:0] w_rd_word;
    logic                  w_push;
    logic                  w_pop;

    logic                  r_inflight;
    logic                  r_inf_fault;
    logic [1:0]            r_cnt;
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [RV_IR_SIZE-1:0] r_buf [2];
    logic [15:0]           r_fault_cnt;

    // BASE_ADDR is aligned to the array size, so any high offset bit means out of range.
    assign w_off   = fch_req_pc - BASE_ADDR;
    assign w_fault = (w_off[1:0] != 2'b00) | (w_off[RV_PC_SIZE-1:AW+2] != '0);

    assign w_occ       = {1'b0, r_cnt} + {2'b00, r_inflight};
    assign fch_rsp_vld = (r_cnt != 2'd0) | r_inflight;
    assign w_rsp_hsk   = fch_rsp_vld & fch_rsp_rdy;
    assign fch_req_rdy = ~ld_vld & ((w_occ < 3'd2) | w_rsp_hsk);
    assign w_req_hsk   = fch_req_vld & fch_req_rdy;

    itcm_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .i_en    (ld_vld | (w_req_hsk & ~w_fault)),
        .i_we    (ld_vld),
        .i_addr  (ld_vld ? ld_addr : w_off[AW+1:2]),
        .i_wdata (ld_data),
        .o_rdata (w_ram_rdata)
    );

    assign w_rd_word = r_inf_fault ? RV_IR_ILLEGAL : w_ram_rdata;

    // Head entry wins; the incoming word bypasses only into an empty buffer.
    always_comb begin
        fch_rsp_ir = '0;
        if (r_cnt != 2'd0) fch_rsp_ir = r_buf[r_rd_ptr];
        else if (r_inflight) fch_rsp_ir = w_rd_word;
    end

    assign w_pop  = w_rsp_hsk & (r_cnt != 2'd0);
    assign w_push = r_inflight & ~((r_cnt == 2'd0) & w_rsp_hsk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= 1'b0;
            r_inf_fault <= 1'b0;
            r_cnt       <= 2'd0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
        end else begin
            r_inflight  <= w_req_hsk;
            r_inf_fault <= w_req_hsk & w_fault;
            r_cnt       <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wr_ptr] <= w_rd_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fault_cnt <= 16'd0;
        else if (w_req_hsk & w_fault & (r_fault_cnt != FAULT_CNT_MAX))
            r_fault_cnt <= r_fault_cnt + 16'd1;
    end

    assign fault_cnt = r_fault_cnt;
endmodule

// File: tb/tb_itcm.sv
// Directed test of the instruction TCM: latency, backpressure, faults, load port, reset.
module tb_itcm;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fch_req_vld;
    logic        fch_req_rdy;
    logic [31:0] fch_req_pc;
    logic        fch_rsp_vld;
    logic        fch_rsp_rdy;
    logic [31:0] fch_rsp_ir;
    logic        ld_vld;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;
    logic [15:0] fault_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    itcm #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fch_req_vld (fch_req_vld),
        .fch_req_rdy (fch_req_rdy),
        .fch_req_pc  (fch_req_pc),
        .fch_rsp_vld (fch_rsp_vld),
        .fch_rsp_rdy (fch_rsp_rdy),
        .fch_rsp_ir  (fch_rsp_ir),
        .ld_vld      (ld_vld),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .fault_cnt   (fault_cnt)
    );

    always #5 clk = ~clk;

    // Each step: drive at negedge, let combinational outputs settle, then compare.
    task automatic step(input logic rv, input logic [31:0] pc, input logic rr);
        @(negedge clk);
        fch_req_vld = rv;
        fch_req_pc  = pc;
        fch_rsp_rdy = rr;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; fch_req_vld = 1'b0; fch_req_pc = '0; fch_rsp_rdy = 1'b1;
        ld_vld = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (fch_rsp_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", fch_rsp_vld); else n_pass++;
        n_chk++; if (fch_rsp_ir !== 32'h0) $display("FAIL reset_ir got=%h exp=0", fch_rsp_ir); else n_pass++;
        n_chk++; if (fch_req_rdy !== 1'b1) $display("FAIL reset_rdy got=%b exp=1", fch_req_rdy); else n_pass++;
        n_chk++; if (fault_cnt !== 16'h0) $display("FAIL reset_fcnt got=%h exp=0", fault_cnt); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic load_word(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_vld = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_vld = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_ir [3];
        exp_ir[0] = 32'h0000_0013; exp_ir[1] = 32'h0010_0093; exp_ir[2] = 32'h0020_0113;
        for (int i = 0; i < 3; i++) load_word(12'(i), exp_ir[i]);
        step(1'b1, 32'h0, 1'b1);
        n_chk++; if (fch_req_rdy !== 1'b1 || fch_rsp_vld !== 1'b0)
            $display("FAIL b2b_first got rdy=%b vld=%b exp rdy=1 vld=0", fch_req_rdy, fch_rsp_vld); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(i < 2, 32'(4 * (i + 1)), 1'b1);
            n_chk++; if (fch_rsp_vld !== 1'b1 || fch_rsp_ir !== exp_ir[i] || fch_req_rdy !== 1'b1)
                $display("FAIL b2b_word%0d got vld=%b ir=%h rdy=%b exp vld=1 ir=%h rdy=1",
                         i, fch_rsp_vld, fch_rsp_ir, fch_req_rdy, exp_ir[i]); else n_pass++;
        end
        step(1'b0, 32'h0, 1'b1);
        n_chk++; if (fch_rsp_vld !== 1'b0) $display("FAIL b2b_drain got vld=%b exp=0", fch_rsp_vld); else n_pass++;
    endtask

    task automatic test_backpressure;
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h4, 1'b0);
        n_chk++; if (fch_req_rdy !== 1'b1 || fch_rsp_ir !== 32'h0000_0013)
            $display("FAIL bp_second_accept got rdy=%b ir=%h exp rdy=1 ir=00000013", fch_req_rdy, fch_rsp_ir); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 32'h8, 1'b0);
            n_chk++; if (fch_req_rdy !== 1'b0 || fch_rsp_vld !== 1'b1 || fch_rsp_ir !== 32'h0000_0013)
                $display("FAIL bp_hold%0d got rdy=%b vld=%b ir=%h exp rdy=0 vld=1 ir=00000013",
                         i, fch_req_rdy, fch_rsp_vld, fch_rsp_ir); else n_pass++;
        end
        step(1'b0, 32'h0, 1'b1);
        n_chk++; if (fch_rsp_ir !== 32'h0000_0013 || fch_req_rdy !== 1'b1)
            $display("FAIL bp_release0 got ir=%h rdy=%b exp ir=00000013 rdy=1", fch_rsp_ir, fch_req_rdy); else n_pass++;
        step(1'b0, 32'h0, 1'b1);
        n_chk++; if (fch_rsp_vld !== 1'b1 || fch_rsp_ir !== 32'h0010_0093)
            $display("FAIL bp_release1 got vld=%b ir=%h exp vld=1 ir=00100093", fch_rsp_vld, fch_rsp_ir); else n_pass++;
        step(1'b0, 32'h0, 1'b1);
        n_chk++; if (fch_rsp_vld !== 1'b0 || fch_req_rdy !== 1'b1)
            $display("FAIL bp_empty got vld=%b rdy=%b exp vld=0 rdy=1", fch_rsp_vld, fch_req_rdy); else n_pass++;
    endtask

    task automatic test_fault;
        step(1'b1, 32'h2, 1'b1);
        step(1'b1, 32'(4 * DEPTH), 1'b1);
        n_chk++; if (fch_rsp_vld !== 1'b1 || fch_rsp_ir !== 32'h0 || fault_cnt !== 16'd1)
            $display("FAIL fault_misalign got vld=%b ir=%h fcnt=%0d exp vld=1 ir=0 fcnt=1",
                     fch_rsp_vld, fch_rsp_ir, fault_cnt); else n_pass++;
        step(1'b0, 32'h0, 1'b1);
        n_chk++; if (fch_rsp_vld !== 1'b1 || fch_rsp_ir !== 32'h0 || fault_cnt !== 16'd2)
            $display("FAIL fault_range got vld=%b ir=%h fcnt=%0d exp vld=1 ir=0 fcnt=2",
                     fch_rsp_vld, fch_rsp_ir, fault_cnt); else n_pass++;
    endtask

    task automatic test_load_block;
        @(negedge clk);
        ld_vld = 1'b1; ld_addr = 12'd5; ld_data = 32'hDEAD_BEEF;
        fch_req_vld = 1'b1; fch_req_pc = 32'h14; fch_rsp_rdy = 1'b1;
        #1;
        n_chk++; if (fch_req_rdy !== 1'b0) $display("FAIL ld_block got rdy=%b exp=0", fch_req_rdy); else n_pass++;
        @(negedge clk);
        ld_vld = 1'b0;
        #1;
        n_chk++; if (fch_req_rdy !== 1'b1 || fch_rsp_vld !== 1'b0)
            $display("FAIL ld_next got rdy=%b vld=%b exp rdy=1 vld=0", fch_req_rdy, fch_rsp_vld); else n_pass++;
        step(1'b0, 32'h0, 1'b1);
        n_chk++; if (fch_rsp_vld !== 1'b1 || fch_rsp_ir !== 32'hDEAD_BEEF)
            $display("FAIL ld_readback got vld=%b ir=%h exp vld=1 ir=deadbeef", fch_rsp_vld, fch_rsp_ir); else n_pass++;
    endtask

    task automatic test_reset_midop;
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h4, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        n_chk++; if (fch_rsp_vld !== 1'b1 || fch_req_rdy !== 1'b0)
            $display("FAIL rst_pre got vld=%b rdy=%b exp vld=1 rdy=0", fch_rsp_vld, fch_req_rdy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (fch_rsp_vld !== 1'b0 || fch_rsp_ir !== 32'h0 || fch_req_rdy !== 1'b1 || fault_cnt !== 16'h0)
            $display("FAIL rst_async got vld=%b ir=%h rdy=%b fcnt=%h exp vld=0 ir=0 rdy=1 fcnt=0",
                     fch_rsp_vld, fch_rsp_ir, fch_req_rdy, fault_cnt); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'h0, 1'b1);
            n_chk++; if (fch_rsp_vld !== 1'b0) $display("FAIL rst_quiet%0d got vld=%b exp=0", i, fch_rsp_vld); else n_pass++;
        end
        step(1'b1, 32'h8, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        n_chk++; if (fch_rsp_vld !== 1'b1 || fch_rsp_ir !== 32'h0020_0113)
            $display("FAIL rst_refetch got vld=%b ir=%h exp vld=1 ir=00200113", fch_rsp_vld, fch_rsp_ir); else n_pass++;
    endtask

    task automatic test_fault_saturate;
        @(negedge clk);
        fch_req_vld = 1'b0;
        force dut.r_fault_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_fault_cnt;
        #1;
        n_chk++; if (fault_cnt !== 16'hFFFE) $display("FAIL sat_preset got=%h exp=fffe", fault_cnt); else n_pass++;
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i + 1), 1'b1);
        n_chk++; if (fault_cnt !== 16'hFFFF) $display("FAIL sat_mid got=%h exp=ffff", fault_cnt); else n_pass++;
        step(1'b0, 32'h0, 1'b1);
        n_chk++; if (fault_cnt !== 16'hFFFF || fch_rsp_ir !== 32'h0)
            $display("FAIL sat_final got fcnt=%h ir=%h exp fcnt=ffff ir=0", fault_cnt, fch_rsp_ir); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_backpressure;
        test_fault;
        test_load_block;
        test_reset_midop;
        test_fault_saturate;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
